div_ctrl: RTL and testbench

Multi-cycle sequencing controller for the EX-stage array divider. It sits directly upstream of the combinational signed divider, which it feeds through `div_en`, `div_op1` and `div_op2`. It latches the operands, holds them stable while the long array path settles, and then captures and selects the quotient or remainder. It stalls the pipeline for the duration and applies the architectural corrections for divide-by-zero and signed overflow.

---
 rtl/div_ctrl_if.sv | 28 ++
 rtl/div_ctrl.sv | 132 +++++++++++++
 tb/tb_div_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_if.sv
// Handshake and data bundle between EX, the div_ctrl sequencer and the array divider.
// The master side is the pipeline plus divider; the slave side is div_ctrl.
interface div_ctrl_if #(
    parameter int DATA_BUS_WIDTH = 32
);
    logic                          start;
    logic                          want_rem;
    logic [DATA_BUS_WIDTH-1:0]     operand_1;
    logic [DATA_BUS_WIDTH-1:0]     operand_2;
    logic                          flush;
    logic                          div_en;
    logic [DATA_BUS_WIDTH-1:0]     div_op1;
    logic [DATA_BUS_WIDTH-1:0]     div_op2;
    logic [2*DATA_BUS_WIDTH-1:0]   div_result;
    logic                          stall_req;
    logic                          done;
    logic [DATA_BUS_WIDTH-1:0]     result;

    modport master (
        output start, want_rem, operand_1, operand_2, flush, div_result,
        input  div_en, div_op1, div_op2, stall_req, done, result
    );

    modport slave (
        input  start, want_rem, operand_1, operand_2, flush, div_result,
        output div_en, div_op1, div_op2, stall_req, done, result
    );
endinterface

// File: rtl/div_ctrl.sv
// Multi-cycle sequencer for the combinational signed array divider, with stall and corrections.
// Optional macro DIV_FAST_PATH_EN: trivial operands (x/0, MIN/-1, 0/x) complete in one cycle.
module div_ctrl #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int DATA_BUS_WIDTH = 32
) (
    input logic       clk,
    input logic       rst_n,
    div_ctrl_if.slave bus
);
    localparam int W = DATA_BUS_WIDTH;
    localparam logic [3:0]   COUNT_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [W-1:0] MOST_NEG   = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ALL_ONES   = '1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state_q, state_d;
    logic [3:0]   count_q, count_d;
    logic         div_en_q, div_en_d;
    logic         done_q, done_d;
    logic [W-1:0] result_q, result_d;
    logic [W-1:0] op1_q, op1_d;
    logic [W-1:0] op2_q, op2_d;
    logic         rem_q, rem_d;
    logic         accept;

    // Architectural fix-ups; a zero raw result doubles as the 0/x fast-path answer.
    function automatic logic [W-1:0] correct(input logic [W-1:0] op1,
                                             input logic [W-1:0] op2,
                                             input logic         rem,
                                             input logic [2*W-1:0] raw);
        if (op2 == '0)
            correct = rem ? op1 : ALL_ONES;
        else if (op1 == MOST_NEG && op2 == ALL_ONES)
            correct = rem ? '0 : op1;
        else
            correct = rem ? raw[2*W-1:W] : raw[W-1:0];
    endfunction

`ifdef DIV_FAST_PATH_EN
    logic fast_hit;
    assign fast_hit = (bus.operand_2 == '0) || (bus.operand_1 == '0) ||
                      (bus.operand_1 == MOST_NEG && bus.operand_2 == ALL_ONES);
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        div_en_d = div_en_q;
        done_d   = 1'b0;
        result_d = result_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        rem_d    = rem_q;
        accept   = (state_q != BUSY) && bus.start && !bus.flush;

        case (state_q)
            IDLE, DONE: begin
                state_d  = IDLE;
                div_en_d = 1'b0;
                if (accept) begin
                    op1_d    = bus.operand_1;
                    op2_d    = bus.operand_2;
                    rem_d    = bus.want_rem;
                    count_d  = COUNT_LOAD;
                    state_d  = BUSY;
                    div_en_d = 1'b1;
`ifdef DIV_FAST_PATH_EN
                    if (fast_hit) begin
                        count_d  = '0;
                        state_d  = DONE;
                        div_en_d = 1'b0;
                        done_d   = 1'b1;
                        result_d = correct(bus.operand_1, bus.operand_2, bus.want_rem, '0);
                    end
`endif
                end
            end
            BUSY: begin
                if (count_q == '0) begin
                    result_d = correct(op1_q, op2_q, rem_q, bus.div_result);
                    done_d   = 1'b1;
                    div_en_d = 1'b0;
                    state_d  = DONE;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over everything: abandon the operation without touching result.
        if (bus.flush) begin
            state_d  = IDLE;
            count_d  = '0;
            div_en_d = 1'b0;
            done_d   = 1'b0;
            result_d = result_q;
        end

        bus.stall_req = accept || (state_q == BUSY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            div_en_q <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            rem_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            div_en_q <= div_en_d;
            done_q   <= done_d;
            result_q <= result_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            rem_q    <= rem_d;
        end
    end

    assign bus.div_en  = div_en_q;
    assign bus.div_op1 = op1_q;
    assign bus.div_op2 = op2_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl with a behavioural model of the array divider.
// Latency expectations follow DIV_FAST_PATH_EN when the bench is built with it.
module tb_div_ctrl;
    localparam int SETTLE = 4;
`ifdef DIV_FAST_PATH_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic        rem;
        logic [31:0] expected;
        bit          fast;
        string       name;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vec [13];

    div_ctrl_if #(.DATA_BUS_WIDTH(32)) bus ();

    div_ctrl #(.SETTLE_CYCLES(SETTLE), .DATA_BUS_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: garbage on the cases the controller must correct itself.
    always_comb begin
        logic signed [31:0] n;
        logic signed [31:0] d;
        n = bus.div_op1;
        d = bus.div_op2;
        if (d == 32'sd0 || (n == 32'sh8000_0000 && d == -32'sd1))
            bus.div_result = 64'hBAD0_BAD0_BAD0_BAD0;
        else
            bus.div_result = {32'(n % d), 32'(n / d)};
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives start at the current sample point and follows the operation to its done cycle.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic rem,
                                 input logic [31:0] expected, input bit fast, input string name);
        int   cyc;
        int   lat;
        logic en_exp;
        logic stall_ok;
        logic path_ok;
        lat    = (FAST_EN && fast) ? 1 : SETTLE + 1;
        en_exp = (FAST_EN && fast) ? 1'b0 : 1'b1;
        bus.start     = 1'b1;
        bus.want_rem  = rem;
        bus.operand_1 = a;
        bus.operand_2 = b;
        #1;
        stall_ok = (bus.stall_req === 1'b1);
        path_ok  = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.want_rem  = 1'($urandom);
        bus.operand_1 = $urandom;
        bus.operand_2 = $urandom;
        #1;
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 40) begin
            if (bus.stall_req !== 1'b1) stall_ok = 1'b0;
            if (bus.div_en !== en_exp) path_ok = 1'b0;
            if (en_exp && (bus.div_op1 !== a || bus.div_op2 !== b)) path_ok = 1'b0;
            @(negedge clk);
            #1;
            cyc++;
        end
        if (bus.stall_req !== 1'b0) stall_ok = 1'b0;
        if (bus.div_en !== 1'b0) path_ok = 1'b0;
        checkOutput({name, "_latency"}, 32'(cyc), 32'(lat));
        checkOutput({name, "_result"}, bus.result, expected);
        checkOutput({name, "_stall"}, {31'd0, stall_ok}, 32'd1);
        checkOutput({name, "_div_en_ops"}, {31'd0, path_ok}, 32'd1);
    endtask

    initial begin
        logic no_done;
        checks = 0;
        errors = 0;
        vec[0]  = '{32'd100,       32'd7,          1'b0, 32'd14,         1'b0, "q_100_7"};
        vec[1]  = '{32'd100,       32'd7,          1'b1, 32'd2,          1'b0, "r_100_7"};
        vec[2]  = '{32'hFFFF_FFF9, 32'd2,          1'b0, 32'hFFFF_FFFD,  1'b0, "q_m7_2"};
        vec[3]  = '{32'hFFFF_FFF9, 32'd2,          1'b1, 32'hFFFF_FFFF,  1'b0, "r_m7_2"};
        vec[4]  = '{32'd5,         32'd0,          1'b0, 32'hFFFF_FFFF,  1'b1, "q_5_0"};
        vec[5]  = '{32'd5,         32'd0,          1'b1, 32'd5,          1'b1, "r_5_0"};
        vec[6]  = '{32'h8000_0000, 32'hFFFF_FFFF,  1'b0, 32'h8000_0000,  1'b1, "q_min_m1"};
        vec[7]  = '{32'h8000_0000, 32'hFFFF_FFFF,  1'b1, 32'd0,          1'b1, "r_min_m1"};
        vec[8]  = '{32'd0,         32'd9,          1'b0, 32'd0,          1'b1, "q_0_9"};
        vec[9]  = '{32'd7,         32'hFFFF_FFFE,  1'b0, 32'hFFFF_FFFD,  1'b0, "q_7_m2"};
        vec[10] = '{32'd7,         32'hFFFF_FFFE,  1'b1, 32'd1,          1'b0, "r_7_m2"};
        vec[11] = '{32'h8000_0000, 32'd1,          1'b0, 32'h8000_0000,  1'b0, "q_min_1"};
        vec[12] = '{32'hFFFF_FF9C, 32'd7,          1'b1, 32'hFFFF_FFFE,  1'b0, "r_m100_7"};

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.want_rem  = 1'b0;
        bus.flush     = 1'b0;
        bus.operand_1 = '0;
        bus.operand_2 = '0;
        #12;
        checkOutput("reset_done", {31'd0, bus.done}, 32'd0);
        checkOutput("reset_div_en", {31'd0, bus.div_en}, 32'd0);
        checkOutput("reset_result", bus.result, 32'd0);
        checkOutput("reset_stall", {31'd0, bus.stall_req}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vec[i]) begin
            applyStimulus(vec[i].op1, vec[i].op2, vec[i].rem, vec[i].expected, vec[i].fast, vec[i].name);
            @(negedge clk);
        end

        // Flush in the second BUSY cycle: no done, result keeps the last table answer.
        bus.start = 1'b1; bus.want_rem = 1'b0; bus.operand_1 = 32'd100; bus.operand_2 = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        checkOutput("flush_stall", {31'd0, bus.stall_req}, 32'd0);
        checkOutput("flush_div_en", {31'd0, bus.div_en}, 32'd0);
        no_done = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (bus.done !== 1'b0) no_done = 1'b0;
            @(negedge clk);
            #1;
        end
        checkOutput("flush_no_done", {31'd0, no_done}, 32'd1);
        checkOutput("flush_result_held", bus.result, vec[12].expected);

        // start together with flush is ignored.
        bus.start = 1'b1; bus.flush = 1'b1; bus.operand_1 = 32'd50; bus.operand_2 = 32'd5;
        #1;
        checkOutput("start_flush_stall", {31'd0, bus.stall_req}, 32'd0);
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        #1;
        checkOutput("start_flush_div_en", {31'd0, bus.div_en}, 32'd0);
        @(negedge clk);

        // Back-to-back: second start issued in the first operation's done cycle.
        applyStimulus(32'd20, 32'd4, 1'b0, 32'd5, 1'b0, "b2b_first");
        applyStimulus(32'd9, 32'd3, 1'b0, 32'd3, 1'b0, "b2b_second");
        @(negedge clk);

        // Asynchronous reset in the middle of BUSY.
        bus.start = 1'b1; bus.want_rem = 1'b1; bus.operand_1 = 32'd100; bus.operand_2 = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_div_en", {31'd0, bus.div_en}, 32'd0);
        checkOutput("rst_mid_div_op1", bus.div_op1, 32'd0);
        checkOutput("rst_mid_div_op2", bus.div_op2, 32'd0);
        checkOutput("rst_mid_done", {31'd0, bus.done}, 32'd0);
        checkOutput("rst_mid_result", bus.result, 32'd0);
        checkOutput("rst_mid_stall", {31'd0, bus.stall_req}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(32'd100, 32'd7, 1'b0, 32'd14, 1'b0, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
